ram_scan_reader: RTL and testbench

// - Read-side companion to the switch-driven RAM writer: walks the 32x8 lpm RAM address by address.
// - Presents each {address, data} pair on a valid/ready stream feeding the HEX display path.
// - A pacing tick sets the dwell time per entry.
// - Yields the RAM port whenever the writer holds it (wr_busy).

---
 rtl/ram_scan_reader.sv | 129 ++++++++++++
 tb/tb_ram_scan_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Scans the 32x8 RAM one address at a time and presents each {address, data} pair on a valid/ready stream.
// Build option RD_SKIP_ZERO_EN: entries that read back as zero are skipped with no presentation and no dwell.
module ram_scan_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              one_shot,
    input  logic              tick,
    input  logic              wr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DWELL} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic              mode;
    logic              skip;
    logic              last;
    logic              advance;

`ifdef RD_SKIP_ZERO_EN
    assign skip = (ram_q == '0);
`else
    assign skip = 1'b0;
`endif

    // A one-shot pass ends on the entry whose count is DEPTH-1.
    assign last    = mode && (cnt == {ADDR_W{1'b1}});
    assign advance = !stop && (((state == DWELL) && tick) || ((state == WAIT) && skip));
    assign busy    = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = ISSUE;
            ISSUE:   if (!wr_busy)  state_next = WAIT;
            WAIT:    state_next = skip ? (last ? IDLE : ISSUE) : PRESENT;
            PRESENT: if (out_ready) state_next = DWELL;
            DWELL:   if (tick)      state_next = last ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            ram_addr  <= '0;
            ram_rden  <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Abort keeps the last presented pair visible on out_addr/out_data.
                out_valid <= 1'b0;
                ram_rden  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ptr  <= start_addr;
                            cnt  <= '0;
                            mode <= one_shot;
                        end
                    end
                    ISSUE: begin
                        if (!wr_busy) begin
                            ram_addr <= ptr;
                            ram_rden <= 1'b1;
                        end
                    end
                    WAIT: begin
                        ram_rden <= 1'b0;
                        if (!skip) begin
                            out_data  <= ram_q;
                            out_addr  <= ptr;
                            out_valid <= 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
                if (advance) begin
                    if (last) begin
                        done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: a RAM model feeds ram_q and expected {addr,data} pairs are queued per scan.
module tb_ram_scan_reader;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] start_addr = '0;
    logic       one_shot = 1'b0;
    logic       tick = 1'b0;
    logic       wr_busy = 1'b0;
    logic [4:0] ram_addr;
    logic       ram_rden;
    logic [7:0] ram_q;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_addr;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    logic [7:0]  mem [32];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    logic [4:0]  last_addr = '0;
    logic        tick_en = 1'b0;

    ram_scan_reader dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .start_addr(start_addr),
        .one_shot  (one_shot),
        .tick      (tick),
        .wr_busy   (wr_busy),
        .ram_addr  (ram_addr),
        .ram_rden  (ram_rden),
        .ram_q     (ram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Read data appears in the cycle after ram_addr is registered.
    assign ram_q = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pass(input logic [4:0] first, input int n);
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a = first + 5'(i);
            exp_q.push_back({19'd0, a, mem[a]});
        end
    endtask

    task automatic do_start(input logic [4:0] a, input logic os);
        start_addr = a;
        one_shot   = os;
        start      = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            tick = tick_en && (cyc % 4 == 0);
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLOCK_50);
            #1;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_addr = out_addr;
                if (exp_q.size() == 0) begin
                    check("hs_extra_queue_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("hs_entry", {19'd0, out_addr, out_data}, e);
                end
            end
        end
    end

    initial begin
        int d0, h0, first, bad;

        for (int i = 0; i < 32; i++) mem[i] = 8'(i) + 8'h10;

        #3;
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_rden", 32'(ram_rden), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);

        // Full one-shot pass from address 0.
        tick_en = 1'b1;
        out_ready = 1'b1;
        d0 = done_cnt;
        h0 = hs_cnt;
        push_pass(5'd0, 32);
        do_start(5'd0, 1'b1);
        wait_idle("t1_idle", 2000);
        #2;
        check("t1_hs_count", 32'(hs_cnt - h0), 32'd32);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge CLOCK_50);

        // One-shot pass starting near the top wraps through zero.
        d0 = done_cnt;
        h0 = hs_cnt;
        push_pass(5'd30, 32);
        do_start(5'd30, 1'b1);
        wait_idle("t2_idle", 2000);
        #2;
        check("t2_hs_count", 32'(hs_cnt - h0), 32'd32);
        check("t2_done_count", 32'(done_cnt - d0), 32'd1);
        check("t2_last_addr", 32'(last_addr), 32'd29);
        @(negedge CLOCK_50);

        // Continuous scan with the writer holding the RAM right after the start edge.
        tick_en = 1'b0;
        tick = 1'b0;
        push_pass(5'd5, 1);
        do_start(5'd5, 1'b0);
        wr_busy = 1'b1;
        bad = 0;
        first = 0;
        for (int k = 2; k <= 14; k++) begin
            @(negedge CLOCK_50);
            if (ram_rden && k <= 6) bad++;
            if (k == 6) wr_busy = 1'b0;
            if (out_valid && first == 0) first = k;
        end
        check("t3_rden_while_busy", 32'(bad), 32'd0);
        check("t3_first_valid_edge", 32'(first), 32'd8);
        check("t3_ram_addr", 32'(ram_addr), 32'd5);

        // Stop while dwelling: back to IDLE, last pair retained, no done.
        d0 = done_cnt;
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        check("t5_busy_after_stop", 32'(busy), 32'd0);
        check("t5_valid_after_stop", 32'(out_valid), 32'd0);
        check("t5_out_addr_kept", 32'(out_addr), 32'd5);
        check("t5_out_data_kept", 32'(out_data), 32'(mem[5]));
        #2;
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        @(negedge CLOCK_50);

        start = 1'b1;
        stop = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        stop = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);
        @(negedge CLOCK_50);

        // Consumer stalls in PRESENT; stray ticks and a start while busy must not disturb it.
        tick_en = 1'b1;
        out_ready = 1'b0;
        push_pass(5'd12, 1);
        do_start(5'd12, 1'b0);
        first = 0;
        while (!out_valid && first < 20) begin
            @(negedge CLOCK_50);
            first++;
        end
        check("t4_valid", 32'(out_valid), 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK_50);
            start_addr = 5'd0;
            start = (k == 3);
            if (!out_valid || out_addr != 5'd12 || out_data != mem[12]) bad++;
        end
        start = 1'b0;
        check("t4_stable", 32'(bad), 32'd0);
        check("t4_out_addr", 32'(out_addr), 32'd12);
        push_pass(5'd13, 1);
        h0 = hs_cnt;
        out_ready = 1'b1;
        first = 0;
        while (hs_cnt < h0 + 2 && first < 60) begin
            @(negedge CLOCK_50);
            #2;
            first++;
        end
        tick_en = 1'b0;
        tick = 1'b0;
        check("t4_hs_count", 32'(hs_cnt - h0), 32'd2);
        @(negedge CLOCK_50);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        check("t4_stopped", 32'(busy), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef RD_SKIP_ZERO_EN
        // Sparse RAM: only nonzero words are presented.
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[3] = 8'hA5;
        mem[17] = 8'h5A;
        exp_q.push_back({19'd0, 5'd3, 8'hA5});
        exp_q.push_back({19'd0, 5'd17, 8'h5A});
        tick_en = 1'b1;
        d0 = done_cnt;
        h0 = hs_cnt;
        @(negedge CLOCK_50);
        do_start(5'd0, 1'b1);
        wait_idle("t6_idle", 2000);
        #2;
        check("t6_hs_count", 32'(hs_cnt - h0), 32'd2);
        check("t6_done_count", 32'(done_cnt - d0), 32'd1);
`endif

        @(negedge CLOCK_50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
